button_entry: RTL
=================

# button_entry

Input-side counterpart of the seven-segment display path. Conditions the five raw board push-buttons and turns them into a 16-bit hex value the user edits digit by digit. The value feeds the seven-segment controller's displayed number. Provides synchronization, per-button debounce, single-cycle press pulses, a digit cursor and per-digit increment/decrement editing.

## Interface
- DEBOUNCE_CYCLES, 1_000_000, consecutive cycles a synchronized input must disagree with the debounced level before the level flips (10 ms at 100 MHz); legal range ≥ 1
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- btns  in  5  raw asynchronous buttons, active-high; [0] center, [1] up, [2] left, [3] right, [4] down
- stable  out  5  debounced button levels
- press  out  5  one-cycle pulse per debounced rising edge
- value  out  16  edited number, 4 hex digits, digit 0 = [3:0]
- cursor  out  2  index of the digit being edited

## Operation
- Reset: sync flops, debounce counters, stable, press, value, cursor all 0. Reset asserted mid-debounce discards partial counts.
- Synchronizer: two flops per button; only the second flop's output (sync) is used downstream.
- Debounce, per button:
  - sync == stable: counter cleared.
  - Otherwise counter increments. When it would reach DEBOUNCE_CYCLES, stable toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
  - Counter width $clog2(DEBOUNCE_CYCLES+1).
- press[i] is registered. It is high for exactly the cycle in which stable[i] first reads 1. Releases produce no pulse.
- Edit actions are taken from press. One action per cycle, priority center > up > down > left > right; lower-priority pulses in the same cycle are dropped, not queued.
  - center: value ← 0, cursor ← 0.
  - up: digit[cursor] ← digit+1 mod 16 (F→0); other digits unchanged.
  - down: digit[cursor] ← digit−1 mod 16 (0→F).
  - left: cursor ← cursor+1 mod 4 (3→0).
  - right: cursor ← cursor−1 mod 4 (0→3).
- Holding a button produces one action only; there is no auto-repeat.

## Timing
- Let raw btns[i] rise and stay high, with first sampling edge E0.
  - sync rises at E1.
  - stable rises at E1+DEBOUNCE_CYCLES.
  - press is high for the cycle following that edge.
  - value/cursor update at the next edge, E2+DEBOUNCE_CYCLES.
- Total raw-to-value latency is DEBOUNCE_CYCLES+2 edges after the first sampling edge (E0).
- Release latency to stable falling is identical; nothing else changes.
- Outputs are registered and glitch-free. value is stable for the display's multiplexing regardless of button activity.

## Structure
- Package button_entry_pkg:
  - button index constants BTN_CENTER=0, BTN_UP=1, BTN_LEFT=2, BTN_RIGHT=3, BTN_DOWN=4
  - N_BTNS=5, N_DIGITS=4
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst_n, raw, stable, press):
  - contains the 2-flop sync, counter and edge pulse
  - instantiated N_BTNS times via generate
- Top holds the priority select and value/cursor registers. Digit update uses a 4-bit wrap adder on the nibble selected by cursor.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset: hold rst_n=0 with btns=5'h1F → stable, press, value, cursor all 0. Release reset with btns=0 → outputs stay 0.
- Glitch: btns[1] high for 3 cycles then low → stable[1] never rises, press stays 0, value stays 16'h0000.
- Latency: btns[1] high from E0 →
  - stable[1] rises at E5
  - press[1] high for exactly one cycle
  - value=16'h0001 at E6
  - hold 50 cycles → value unchanged.
- Wrap and editing sequence: from reset →
  - 16 up presses → value 16'h0000 again
  - one down → 16'h000F
  - right → cursor 3
  - up → 16'h100F
  - left → cursor 0
  - center → value 0, cursor 0.
- Simultaneous: press up and left with the same raw edge → only up applies (value 16'h0001, cursor 0). Then center+down together → value 0.
- Reset mid-debounce: btns[4] high, rst_n pulsed low at E2, btns[4] held → stable[4] rises 5 edges after reset release, not earlier; value digit 0 = F.

Source files
------------

// File: rtl/button_entry_pkg.sv
// Shared constants and helpers for the push-button hex entry path.
// Button indices, edit-action encoding and the nibble wrap adder live here.
package button_entry_pkg;

  localparam int N_BTNS   = 5;
  localparam int N_DIGITS = 4;

  localparam int BTN_CENTER = 0;
  localparam int BTN_UP     = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_DOWN   = 4;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_CLEAR,
    ACT_INC,
    ACT_DEC,
    ACT_CUR_UP,
    ACT_CUR_DOWN
  } action_e;

  // Only the highest-priority press in a cycle becomes an action; the rest are dropped.
  function automatic action_e select_action(input logic [N_BTNS-1:0] p);
    if (p[BTN_CENTER])     return ACT_CLEAR;
    else if (p[BTN_UP])    return ACT_INC;
    else if (p[BTN_DOWN])  return ACT_DEC;
    else if (p[BTN_LEFT])  return ACT_CUR_UP;
    else if (p[BTN_RIGHT]) return ACT_CUR_DOWN;
    else                   return ACT_NONE;
  endfunction

  function automatic logic [3:0] nibble_step(input logic [3:0] d, input logic dec);
    return dec ? d - 4'd1 : d + 4'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: 2-flop synchronizer, debounce counter and
// a registered pulse on each debounced rising edge.
module btn_debounce
  import button_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic             flip;

  // The level flips on the cycle the disagreement run would reach DEBOUNCE_CYCLES.
  assign flip = (sync_p1 != stable) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      stable  <= 1'b0;
      press   <= 1'b0;
    end else begin
      // sync stage boundary
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      // debounce stage boundary
      if (sync_p1 == stable) begin
        cnt <= '0;
      end else if (flip) begin
        cnt    <= '0;
        stable <= ~stable;
      end else begin
        cnt <= cnt + 1'b1;
      end
      press <= flip & ~stable;
    end
  end

endmodule

// File: rtl/button_entry.sv
// Five debounced buttons edit a 4-digit hex value: center clears, up/down
// change the digit under the cursor, left/right move the cursor.
module button_entry
  import button_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_BTNS-1:0]     btns,
  output logic [N_BTNS-1:0]     stable,
  output logic [N_BTNS-1:0]     press,
  output logic [4*N_DIGITS-1:0] value,
  output logic [1:0]            cursor
);

  action_e               action;
  logic [3:0]            digit;
  logic [4*N_DIGITS-1:0] value_next;
  logic [1:0]            cursor_next;

  for (genvar i = 0; i < N_BTNS; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btns[i]),
      .stable(stable[i]),
      .press (press[i])
    );
  end

  always_comb begin
    action      = select_action(press);
    digit       = value[{cursor, 2'b00} +: 4];
    value_next  = value;
    cursor_next = cursor;
    case (action)
      ACT_CLEAR: begin
        value_next  = '0;
        cursor_next = 2'd0;
      end
      ACT_INC:      value_next[{cursor, 2'b00} +: 4] = nibble_step(digit, 1'b0);
      ACT_DEC:      value_next[{cursor, 2'b00} +: 4] = nibble_step(digit, 1'b1);
      ACT_CUR_UP:   cursor_next = cursor + 2'd1;
      ACT_CUR_DOWN: cursor_next = cursor - 2'd1;
      default: ;
    endcase
  end

  // edit stage boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value  <= '0;
      cursor <= 2'd0;
    end else begin
      value  <= value_next;
      cursor <= cursor_next;
    end
  end

endmodule
